// File: rtl/bidir_bus_pkg.sv
// Shared encodings and helpers for the bidirectional bus arbiter/scheduler.
package bidir_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_TURN  = 2'd3;

  localparam int unsigned TURN_W = 2;

  // Per-bit value placed on the pad bus when the block is not driving it.
  localparam logic BUS_RELEASE = 1'bz;

  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin selector: first set request at or after ptr, cyclically.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bidir_bus_arbiter_scheduler.sv
// Round-robin owner of a shared tristate bus: grants bursts, sequences beats,
// and inserts turnaround cycles between bursts.
module bidir_bus_arbiter_scheduler
  import bidir_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BUS_W      = 128,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                     clk_main_domain_100mhz_primary_oscillator,
  input  logic                     reset_system_wide_asynchronous_active_low_synchronized,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_rnw,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*BUS_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]       req_wvalid,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       wready,
  output logic [BUS_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]       rdata_valid,
  output logic [NUM_REQ-1:0]       done,
  inout  wire  [BUS_W-1:0]         bus_io,
  output logic                     bus_oe,
  output logic                     bus_wr_strobe,
  output logic                     bus_rd_strobe,
  output logic [2:0]               bus_owner_id
);

  localparam int unsigned OW = owner_w(NUM_REQ);

  logic clk;
  logic rst_n;
  assign clk   = clk_main_domain_100mhz_primary_oscillator;
  assign rst_n = reset_system_wide_asynchronous_active_low_synchronized;

  logic [LEN_W-1:0] len_a   [NUM_REQ];
  logic [BUS_W-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign len_a[g]   = req_len[g*LEN_W +: LEN_W];
    assign wdata_a[g] = req_wdata[g*BUS_W +: BUS_W];
  end

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic               wr_last_q, wr_last_d;
  logic               rd_last_q, rd_last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               bus_oe_q, bus_oe_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic               rd_strobe_q, rd_strobe_d;
  logic [2:0]         owner_id_q, owner_id_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0] rdata_valid_q, rdata_valid_d;
  logic [BUS_W-1:0]   wdata_q, wdata_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [OW-1:0]      pick_idx;
  logic               pick_any;
  logic               accept_c;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Once the last write beat is accepted, the tail cycle only replays its strobe.
  assign accept_c = (state_q == ST_WRITE) && !wr_last_q && req_wvalid[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      turn_cnt_q    <= '0;
      wr_last_q     <= 1'b0;
      rd_last_q     <= 1'b0;
      grant_q       <= '0;
      bus_oe_q      <= 1'b0;
      wr_strobe_q   <= 1'b0;
      rd_strobe_q   <= 1'b0;
      owner_id_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= '0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      turn_cnt_q    <= turn_cnt_d;
      wr_last_q     <= wr_last_d;
      rd_last_q     <= rd_last_d;
      grant_q       <= grant_d;
      bus_oe_q      <= bus_oe_d;
      wr_strobe_q   <= wr_strobe_d;
      rd_strobe_q   <= rd_strobe_d;
      owner_id_q    <= owner_id_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      wdata_q       <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    turn_cnt_d    = turn_cnt_q;
    wr_last_d     = wr_last_q;
    rd_last_d     = 1'b0;
    grant_d       = grant_q;
    bus_oe_d      = bus_oe_q;
    wr_strobe_d   = 1'b0;
    rd_strobe_d   = rd_strobe_q;
    owner_id_d    = owner_id_q;
    rdata_d       = rdata_q;
    rdata_valid_d = '0;
    wdata_d       = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d    = pick_idx;
          len_d      = len_a[pick_idx];
          cnt_d      = '0;
          wr_last_d  = 1'b0;
          grant_d    = pick_onehot;
          owner_id_d = 3'(pick_idx);
          rr_ptr_d   = (pick_idx == OW'(NUM_REQ - 1)) ? '0 : pick_idx + OW'(1);
          if (req_rnw[pick_idx]) begin
            state_d     = ST_READ;
            rd_strobe_d = 1'b1;
          end else begin
            state_d  = ST_WRITE;
            bus_oe_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (wr_last_q) begin
          state_d    = ST_TURN;
          bus_oe_d   = 1'b0;
          grant_d    = '0;
          owner_id_d = '0;
          turn_cnt_d = '0;
        end else if (accept_c) begin
          wdata_d     = wdata_a[owner_q];
          wr_strobe_d = 1'b1;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) wr_last_d = 1'b1;
        end
      end

      ST_READ: begin
        rdata_d       = bus_io;
        rdata_valid_d = grant_q;
        cnt_d         = cnt_q + LEN_W'(1);
        if (cnt_q == len_q) begin
          rd_last_d   = 1'b1;
          rd_strobe_d = 1'b0;
          state_d     = ST_TURN;
          grant_d     = '0;
          owner_id_d  = '0;
          turn_cnt_d  = '0;
        end
      end

      default: begin
        if (turn_cnt_q == TURN_W'(TURNAROUND - 1)) state_d = ST_IDLE;
        else turn_cnt_d = turn_cnt_q + TURN_W'(1);
      end
    endcase
  end

  assign bus_io = bus_oe_q ? wdata_q : {BUS_W{BUS_RELEASE}};

  assign grant         = grant_q;
  assign wready        = {NUM_REQ{accept_c}} & grant_q;
  assign done          = ({NUM_REQ{accept_c && (cnt_q == len_q)}} & grant_q)
                       | ({NUM_REQ{rd_last_q}} & rdata_valid_q);
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign bus_oe        = bus_oe_q;
  assign bus_wr_strobe = wr_strobe_q;
  assign bus_rd_strobe = rd_strobe_q;
  assign bus_owner_id  = owner_id_q;

endmodule

// File: tb/tb_bidir_bus_arbiter_scheduler.sv
// Scenario-based scoreboard bench for bidir_bus_arbiter_scheduler with a bus device model.
module tb_bidir_bus_arbiter_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned BW = 128;
  localparam int unsigned LW = 4;
  localparam int unsigned TA = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NR-1:0]    req, req_rnw, req_wvalid;
  logic [NR*LW-1:0] req_len;
  logic [NR*BW-1:0] req_wdata;
  logic [NR-1:0]    grant, wready, rdata_valid, done;
  logic [BW-1:0]    rdata;
  wire  [BW-1:0]    bus_io;
  logic             bus_oe, bus_wr_strobe, bus_rd_strobe;
  logic [2:0]       bus_owner_id;

  logic          dev_oe;
  logic [BW-1:0] dev_data;
  logic [BW-1:0] dev_mem [16];
  int            dev_idx;

  int checks;
  int failures;
  logic [BW-1:0] exp_q[$];
  int            exp_gnt_q[$];

  assign bus_io = dev_oe ? dev_data : 'z;

  always #5 clk = ~clk;

  bidir_bus_arbiter_scheduler #(
    .NUM_REQ    (NR),
    .BUS_W      (BW),
    .LEN_W      (LW),
    .TURNAROUND (TA)
  ) dut (
    .clk_main_domain_100mhz_primary_oscillator              (clk),
    .reset_system_wide_asynchronous_active_low_synchronized (rst_n),
    .req           (req),
    .req_rnw       (req_rnw),
    .req_len       (req_len),
    .req_wdata     (req_wdata),
    .req_wvalid    (req_wvalid),
    .grant         (grant),
    .wready        (wready),
    .rdata         (rdata),
    .rdata_valid   (rdata_valid),
    .done          (done),
    .bus_io        (bus_io),
    .bus_oe        (bus_oe),
    .bus_wr_strobe (bus_wr_strobe),
    .bus_rd_strobe (bus_rd_strobe),
    .bus_owner_id  (bus_owner_id)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic idle_inputs();
    req = '0; req_rnw = '0; req_len = '0; req_wvalid = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [LW-1:0] len);
    req[i] = 1'b1; req_rnw[i] = rnw; req_len[i*LW +: LW] = len;
  endtask

  // Device answers each read strobe cycle with the next word of dev_mem.
  task automatic dev_update();
    if (bus_rd_strobe && dev_idx < 16) begin
      dev_oe = 1'b1; dev_data = dev_mem[dev_idx]; dev_idx++;
    end else begin
      dev_oe = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); dev_oe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b exp=0", grant); end
    checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bus_oe); end
    checks++; if ({bus_wr_strobe, bus_rd_strobe} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {bus_wr_strobe, bus_rd_strobe}); end
    checks++; if (rdata !== '0 || rdata_valid !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%b exp=0", rdata, rdata_valid); end
    checks++; if (done !== '0 || wready !== '0 || bus_owner_id !== 3'd0) begin failures++; $display("FAIL reset_misc done=%b wready=%b id=%0d exp=0", done, wready, bus_owner_id); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (grant !== '0 || bus_oe !== 1'b0) begin failures++; $display("FAIL idle_after_reset grant=%b oe=%b exp=0", grant, bus_oe); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] prev_gnt, eg;
    logic prev_rd, drop;
    int e;
    exp_gnt_q.delete(); dev_idx = 0;
    for (int k = 0; k < 16; k++) dev_mem[k] = BW'(32'hE0 + k);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
    exp_gnt_q.push_back(3); exp_gnt_q.push_back(0);
    prev_gnt = '0; prev_rd = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < int'(NR); i++) begin
      set_req(i, (i % 2) == 1, '0);
      req_wdata[i*BW +: BW] = BW'(32'hC0 + i);
    end
    req_wvalid = '1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); dev_update();
      drop = 1'b0;
      if (prev_rd) begin
        checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL rr_oe_after_read cyc=%0d got=%b exp=0", c, bus_oe); end
      end
      if (prev_gnt == '0 && grant != '0) begin
        checks++;
        if (exp_gnt_q.size() == 0) begin
          failures++; $display("FAIL rr_extra_grant got=%b exp=none", grant);
        end else begin
          e = exp_gnt_q.pop_front(); eg = '0; eg[e] = 1'b1;
          if (grant !== eg) begin failures++; $display("FAIL rr_order got=%b exp=%b", grant, eg); end
          if (exp_gnt_q.size() == 0) drop = 1'b1;
        end
      end
      prev_gnt = grant; prev_rd = bus_rd_strobe;
      @(posedge clk); #1;
      if (drop) req = '0;
    end
    checks++; if (exp_gnt_q.size() != 0) begin failures++; $display("FAIL rr_grants_missing got=%0d exp=0", exp_gnt_q.size()); end
    idle_inputs();
  endtask

  task automatic test_single_write();
    int acc, strobes, n_done, last_str;
    logic acc_now, done_now;
    logic [BW-1:0] want;
    acc = 0; strobes = 0; n_done = 0; last_str = -100;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(BW'(8'hA0 + k));
    @(posedge clk); #1;
    set_req(2, 1'b0, 4'd3); req_wvalid[2] = 1'b1; req_wdata[2*BW +: BW] = BW'(8'hA0);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); dev_update();
      if (c == 0) begin
        checks++; if (grant !== '0) begin failures++; $display("FAIL wr_grant_early got=%b exp=0", grant); end
      end
      if (c == 1) begin
        checks++; if (grant !== 4'b0100 || bus_owner_id !== 3'd2) begin failures++; $display("FAIL wr_grant got=%b/%0d exp=0100/2", grant, bus_owner_id); end
      end
      acc_now = wready[2]; done_now = done[2];
      if (acc_now) acc++;
      if (done_now) begin
        n_done++;
        checks++; if (!acc_now || acc != 4) begin failures++; $display("FAIL wr_done_align wready=%b beats=%0d exp=1/4", acc_now, acc); end
      end
      if (bus_wr_strobe) begin
        strobes++; last_str = c;
        want = '0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        checks++; if (bus_oe !== 1'b1 || bus_io !== want) begin failures++; $display("FAIL wr_data got=%h oe=%b exp=%h", bus_io, bus_oe, want); end
      end else if (c > last_str && c <= last_str + int'(TA)) begin
        checks++; if (bus_oe !== 1'b0 || grant !== '0) begin failures++; $display("FAIL wr_turn oe=%b grant=%b exp=0", bus_oe, grant); end
      end
      @(posedge clk); #1;
      if (acc_now) req_wdata[2*BW +: BW] = BW'(8'hA0 + acc);
      if (done_now) begin req[2] = 1'b0; req_wvalid[2] = 1'b0; end
    end
    checks++; if (strobes != 4) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=4", strobes); end
    checks++; if (n_done != 1 || exp_q.size() != 0) begin failures++; $display("FAIL wr_done_count got=%0d left=%0d exp=1/0", n_done, exp_q.size()); end
    idle_inputs();
  endtask

  task automatic test_single_read();
    int n_valid, first_v, last_v;
    logic prev_rd, done_now;
    logic [BW-1:0] want;
    n_valid = 0; first_v = -1; last_v = -1; prev_rd = 1'b0;
    exp_q.delete(); dev_idx = 0;
    dev_mem[0] = BW'(8'h55); dev_mem[1] = BW'(8'hAA);
    exp_q.push_back(BW'(8'h55)); exp_q.push_back(BW'(8'hAA));
    @(posedge clk); #1;
    set_req(0, 1'b1, 4'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); dev_update();
      checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL rd_oe cyc=%0d got=%b exp=0", c, bus_oe); end
      done_now = done[0];
      if (rdata_valid != '0) begin
        n_valid++; if (first_v < 0) first_v = c; last_v = c;
        want = '0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        checks++; if (rdata_valid !== 4'b0001 || !prev_rd || rdata !== want) begin
          failures++; $display("FAIL rd_beat valid=%b prev_strobe=%b got=%h exp=0001/1/%h", rdata_valid, prev_rd, rdata, want);
        end
      end
      if (done_now) begin
        checks++; if (n_valid != 2 || rdata_valid[0] !== 1'b1) begin failures++; $display("FAIL rd_done_align beats=%0d exp=2", n_valid); end
      end
      prev_rd = bus_rd_strobe;
      @(posedge clk); #1;
      if (done_now) req[0] = 1'b0;
    end
    checks++; if (n_valid != 2 || last_v - first_v != 1) begin failures++; $display("FAIL rd_valid_count got=%0d span=%0d exp=2/1", n_valid, last_v - first_v); end
    idle_inputs();
  endtask

  task automatic test_write_gaps();
    logic [11:0] pat;
    int acc, strobes;
    logic acc_now, done_now;
    logic [BW-1:0] want;
    pat = 12'b0000_0001_0011;
    acc = 0; strobes = 0;
    exp_q.delete();
    exp_q.push_back(BW'(8'hB0)); exp_q.push_back(BW'(8'hB1));
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'd1); req_wdata[BW +: BW] = BW'(8'hB0); req_wvalid[1] = pat[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); dev_update();
      acc_now = wready[1]; done_now = done[1];
      if (acc_now) acc++;
      if (grant[1]) begin
        checks++; if (bus_oe !== 1'b1) begin failures++; $display("FAIL gap_oe_held cyc=%0d got=%b exp=1", c, bus_oe); end
      end
      if (done_now) begin
        checks++; if (!acc_now || acc != 2) begin failures++; $display("FAIL gap_done_align wready=%b beats=%0d exp=1/2", acc_now, acc); end
      end
      if (bus_wr_strobe) begin
        strobes++;
        want = '0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        checks++; if (bus_io !== want) begin failures++; $display("FAIL gap_data got=%h exp=%h", bus_io, want); end
      end
      @(posedge clk); #1;
      if (acc_now) req_wdata[BW +: BW] = BW'(8'hB0 + acc);
      if (done_now) req[1] = 1'b0;
      req_wvalid[1] = (c + 1 < 12) ? pat[c+1] : 1'b0;
    end
    checks++; if (strobes != 2) begin failures++; $display("FAIL gap_strobe_count got=%0d exp=2", strobes); end
    idle_inputs();
  endtask

  task automatic test_long_read();
    int n_valid, n_done;
    logic done_now;
    logic [BW-1:0] want;
    n_valid = 0; n_done = 0;
    exp_q.delete(); dev_idx = 0;
    for (int k = 0; k < 16; k++) begin
      dev_mem[k] = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(dev_mem[k]);
    end
    @(posedge clk); #1;
    set_req(2, 1'b1, 4'd15);
    for (int c = 0; c < 26; c++) begin
      @(negedge clk); dev_update();
      done_now = done[2];
      if (rdata_valid != '0) begin
        n_valid++;
        want = '0;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        checks++; if (rdata_valid !== 4'b0100 || rdata !== want) begin failures++; $display("FAIL long_beat%0d valid=%b got=%h exp=0100/%h", n_valid, rdata_valid, rdata, want); end
      end
      if (done_now) begin
        n_done++;
        checks++; if (n_valid != 16) begin failures++; $display("FAIL long_done_pos got=%0d exp=16", n_valid); end
      end
      @(posedge clk); #1;
      if (done_now) req[2] = 1'b0;
    end
    checks++; if (n_valid != 16 || n_done != 1) begin failures++; $display("FAIL long_count valid=%0d done=%0d exp=16/1", n_valid, n_done); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    bit hit;
    acc = 0; hit = 1'b0;
    @(posedge clk); #1;
    set_req(1, 1'b0, 4'd7); req_wvalid[1] = 1'b1; req_wdata[BW +: BW] = BW'(32'hD0);
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk); dev_update();
      if (wready[1]) acc++;
      if (acc == 2) begin
        hit = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus_oe !== 1'b0 || grant !== '0 || bus_wr_strobe !== 1'b0 || bus_rd_strobe !== 1'b0) begin
          failures++; $display("FAIL rst_mid_outputs oe=%b grant=%b wr=%b rd=%b exp=0", bus_oe, grant, bus_wr_strobe, bus_rd_strobe);
        end
        checks++; if (done !== '0 || wready !== '0) begin failures++; $display("FAIL rst_mid_done done=%b wready=%b exp=0", done, wready); end
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rst_mid_reach beats=%0d exp=2", acc); end
    rst_n = 1'b0; idle_inputs();
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (done !== '0 || bus_oe !== 1'b0) begin failures++; $display("FAIL rst_hold done=%b oe=%b exp=0", done, bus_oe); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b0, '0); set_req(3, 1'b0, '0); req_wvalid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); dev_update();
      if (c == 0) begin
        checks++; if (grant !== '0) begin failures++; $display("FAIL rst_idle got=%b exp=0", grant); end
      end
      if (c == 1) begin
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rst_ptr got=%b exp=0010", grant); end
      end
      @(posedge clk); #1;
      if (c == 1) req = '0;
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0; failures = 0;
    dev_oe = 1'b0; dev_idx = 0; dev_data = '0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_single_write();
    test_single_read();
    test_write_gaps();
    test_long_read();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
